// File: rtl/simple_dual_port_mem_pkg.sv
// simple_dual_port_mem_pkg: default geometry shared by memory instances
package simple_dual_port_mem_pkg;
  localparam int DEFAULT_MEM_SIZE = 1024;
  localparam int DEFAULT_DATA_WIDTH = 32;
endpackage

// File: rtl/simple_dual_port_mem.sv
// simple_dual_port_mem: one write port, one registered read-first read port
module simple_dual_port_mem
  import simple_dual_port_mem_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] q
);
  localparam bit POW2 = MEM_SIZE == (1 << ADDR_WIDTH);
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic ra_ok, wa_ok;
  assign ra_ok = POW2 || (int'(ra) < MEM_SIZE);
  assign wa_ok = POW2 || (int'(wa) < MEM_SIZE);
  // array stays out of the reset path so it maps onto block RAM
  always_ff @(posedge clk)
    if (reset && write && wa_ok) mem[wa] <= d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= ra_ok ? mem[ra] : '0;
endmodule

// File: tb/tb_simple_dual_port_mem.sv
// tb_simple_dual_port_mem: vector table, corner sequences and random run against an array model
module tb_simple_dual_port_mem;
  logic clk = 0, reset = 0, write = 0, write2 = 0;
  logic [9:0] ra = 0, wa = 0;
  logic [31:0] d = 0, q;
  logic [2:0] ra2 = 0, wa2 = 0;
  logic [7:0] d2 = 0, q2;
  int pass_cnt = 0, total_cnt = 0;
  logic [31:0] model [1024];

  typedef struct {
    logic w; logic [9:0] wa; logic [31:0] d; logic [9:0] ra; logic chk; logic [31:0] exp;
  } vec_t;
  vec_t tv [9];

  simple_dual_port_mem dut (.clk(clk), .reset(reset), .ra(ra), .wa(wa), .d(d), .write(write), .q(q));
  simple_dual_port_mem #(.MEM_SIZE(6), .DATA_WIDTH(8)) dut_small (
    .clk(clk), .reset(reset), .ra(ra2), .wa(wa2), .d(d2), .write(write2), .q(q2));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h required %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle on the big instance; exp is the read-first word at ra
  task automatic step(input logic w, input logic [9:0] a_w, input logic [31:0] dat,
                      input logic [9:0] a_r, output logic [31:0] exp);
    write = w; wa = a_w; d = dat; ra = a_r;
    exp = model[a_r];
    if (w) model[a_w] = dat;
    cyc();
  endtask

  initial begin
    logic [31:0] e;
    tv[0] = '{1'b1, 10'd5, 32'hDEADBEEF, 10'd0, 1'b0, 32'h0};
    tv[1] = '{1'b0, 10'd0, 32'h0,        10'd5, 1'b1, 32'hDEADBEEF};
    tv[2] = '{1'b1, 10'd7, 32'hAAAAAAAA, 10'd5, 1'b1, 32'hDEADBEEF};
    tv[3] = '{1'b1, 10'd7, 32'h11111111, 10'd7, 1'b1, 32'hAAAAAAAA};
    tv[4] = '{1'b0, 10'd0, 32'h0,        10'd7, 1'b1, 32'h11111111};
    tv[5] = '{1'b1, 10'd3, 32'h00000003, 10'd7, 1'b1, 32'h11111111};
    tv[6] = '{1'b0, 10'd3, 32'hFFFFFFFF, 10'd3, 1'b1, 32'h00000003};
    tv[7] = '{1'b0, 10'd3, 32'hFFFFFFFF, 10'd3, 1'b1, 32'h00000003};
    tv[8] = '{1'b1, 10'd5, 32'h0BADF00D, 10'd5, 1'b1, 32'hDEADBEEF};
    #2;
    check("reset_q", q, 32'h0);
    check("reset_q_small", {24'h0, q2}, 32'h0);
    cyc();
    check("reset_q_held", q, 32'h0);
    #3 reset = 1;
    for (int i = 0; i < 9; i++) begin
      step(tv[i].w, tv[i].wa, tv[i].d, tv[i].ra, e);
      if (tv[i].chk) check($sformatf("vec%0d", i), q, tv[i].exp);
    end
    step(1'b1, 10'd20, 32'hAAAA0001, 10'd0, e);
    step(1'b1, 10'd20, 32'hBBBB0002, 10'd0, e);
    step(1'b0, 10'd0, 32'h0, 10'd20, e);
    check("b2b_last_wins", q, 32'hBBBB0002);
    for (int i = 0; i < 1024; i++) step(1'b1, 10'(i), 32'(i), 10'd0, e);
    step(1'b0, 10'd0, 32'h0, 10'd1023, e);
    check("fill_read_1023", q, 32'd1023);
    step(1'b0, 10'd0, 32'h0, 10'd0, e);
    check("fill_read_0", q, 32'd0);
    step(1'b1, 10'd9, 32'h12345678, 10'd0, e);
    step(1'b0, 10'd0, 32'h0, 10'd9, e);
    check("pre_reset_q", q, 32'h12345678);
    #3 reset = 0;
    #1 check("async_reset_q", q, 32'h0);
    write = 1; wa = 10'd9; d = 32'h0; ra = 10'd9;
    cyc();
    check("reset_hold_q", q, 32'h0);
    #2 reset = 1;
    step(1'b0, 10'd0, 32'h0, 10'd9, e);
    check("post_reset_read9", q, 32'h12345678);
    for (int i = 0; i < 300; i++) begin
      logic [9:0] aw;
      aw = 10'($urandom_range(0, 1023));
      step(1'($urandom), aw, $urandom, ($urandom_range(0, 3) == 0) ? aw : 10'($urandom_range(0, 1023)), e);
      check($sformatf("rand%0d", i), q, e);
    end
    write = 0;
    for (int i = 0; i < 6; i++) begin
      write2 = 1; wa2 = 3'(i); d2 = 8'hA0 + 8'(i);
      cyc();
    end
    wa2 = 3'd7; d2 = 8'h55;
    cyc();
    wa2 = 3'd6; d2 = 8'h66;
    cyc();
    write2 = 0; ra2 = 3'd7;
    cyc();
    check("small_oob_read7", {24'h0, q2}, 32'h0);
    ra2 = 3'd6;
    cyc();
    check("small_oob_read6", {24'h0, q2}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      ra2 = 3'(i);
      cyc();
      check($sformatf("small_read%0d", i), {24'h0, q2}, {24'h0, 8'hA0 + 8'(i)});
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
